// File: rtl/mskg16_sched_pkg.sv
// Shared types and helpers for the masked G(16) multiplier scheduler.
// Field arithmetic is GF(2^4) in polynomial basis, reduction x^4 + x + 1.
package mskg16_sched_pkg;

    localparam int MAX_IDW = 3;
    localparam int PIPE_BASE = 2;
    localparam int RND_W_DEF = 4 * 1 + 4 * 1;
    localparam int PIPE_LAT_DEF = PIPE_BASE + 0;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int rnd_w(input int ref_n, input int dom_n);
        return 4 * ref_n + 4 * dom_n;
    endfunction

    function automatic int pipe_lat(input int ref_lat);
        return PIPE_BASE + ref_lat;
    endfunction

    function automatic logic [3:0] gf16_mul(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--)
            if (p[i]) p = p ^ (7'b0010011 << (i - 4));
        return p[3:0];
    endfunction

endpackage

// File: rtl/MSKg16mul_hpc1.sv
// HPC1 masked G(16) multiplier: SNI refresh on b, then DOM cross products.
// b enters at t, a and DOM randomness at t+1+REF_LAT, out valid at t+2+REF_LAT.
module MSKg16mul_hpc1
    import mskg16_sched_pkg::*;
#(
    parameter int D         = 2,
    parameter int REF_LAT   = 0,
    parameter int REF_N_RND = 1,
    parameter int DOM_RND   = 1
) (
    input  logic                   clk,
    input  logic [4*D-1:0]         ina,
    input  logic [4*D-1:0]         inb,
    input  logic [4*REF_N_RND-1:0] rnd_ref,
    input  logic [4*DOM_RND-1:0]   rnd_mul,
    output logic [4*D-1:0]         out
);

    localparam int W = 4 * D;

    logic [W-1:0] b_ref;
    logic [W-1:0] b_lat;
    logic [W-1:0] b_q;
    logic         acc;
    logic         rb;

    // Last share absorbs the XOR of all masks so the sharing is preserved.
    always_comb begin
        b_ref = inb;
        acc   = 1'b0;
        rb    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            acc = 1'b0;
            for (int s = 0; s < D - 1; s++) begin
                rb = rnd_ref[k*REF_N_RND + (s % REF_N_RND)];
                b_ref[k*D+s] = b_ref[k*D+s] ^ rb;
                acc = acc ^ rb;
            end
            b_ref[k*D+D-1] = b_ref[k*D+D-1] ^ acc;
        end
    end

    if (REF_LAT > 0) begin : g_lat
        logic [W-1:0] b_lat_r;
        always_ff @(posedge clk) b_lat_r <= b_ref;
        assign b_lat = b_lat_r;
    end else begin : g_nolat
        assign b_lat = b_ref;
    end

    always_ff @(posedge clk) b_q <= b_lat;

    logic [3:0] an [D];
    logic [3:0] bn [D];
    logic [3:0] pr [D*D];
    logic [3:0] pq [D*D];
    logic [3:0] mk;
    int         q;

    always_comb begin
        mk = '0;
        q  = 0;
        for (int s = 0; s < D; s++) begin
            for (int k = 0; k < 4; k++) begin
                an[s][k] = ina[k*D+s];
                bn[s][k] = b_q[k*D+s];
            end
        end
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                pr[i*D+j] = gf16_mul(an[i], bn[j]);
                if (i != j) begin
                    q = (i < j) ? i * D + j : j * D + i;
                    for (int k = 0; k < 4; k++)
                        mk[k] = rnd_mul[k*DOM_RND + (q % DOM_RND)];
                    pr[i*D+j] = pr[i*D+j] ^ mk;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < D * D; n++)
            pq[n] <= pr[n];
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++)
                for (int k = 0; k < 4; k++)
                    out[k*D+i] = out[k*D+i] ^ pq[i*D+j][k];
    end

endmodule

// File: rtl/mskg16_sched_rr.sv
// Round-robin arbiter: first valid requester at or after the pointer wins.
module mskg16_sched_rr
    import mskg16_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic [IDW-1:0]  ptr_nxt
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
        ptr_nxt = found ? IDW'((int'(grant_id) + 1) % NREQ) : ptr;
    end

endmodule

// File: rtl/mskg16mul_sched.sv
// Round-robin scheduler in front of one shared MSKg16mul_hpc1 gadget.
// MSKG16_SCHED_ZEROIZE_EN: drive zeros to the gadget on bubble cycles.
module mskg16mul_sched
    import mskg16_sched_pkg::*;
#(
    parameter int D         = 2,
    parameter int NREQ      = 4,
    parameter int REF_LAT   = 0,
    parameter int REF_N_RND = 1,
    parameter int DOM_RND   = 1,
    localparam int RND_W    = rnd_w(REF_N_RND, DOM_RND),
    localparam int IDW      = id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4*D-1:0] req_a,
    input  logic [NREQ*4*D-1:0] req_b,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic [RND_W-1:0]  rnd,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [4*D-1:0]    resp_out,
    output logic              busy
);

    localparam int W  = 4 * D;
    localparam int NR = 4 * REF_N_RND;
    localparam int NM = 4 * DOM_RND;
    localparam int PL = pipe_lat(REF_LAT);
    localparam int DL = 1 + REF_LAT;

    logic           issue;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   g_ina;
    logic [W-1:0]   g_inb;
    logic [NR-1:0]  g_rnd_ref;
    logic [NM-1:0]  g_rnd_mul;

    assign issue     = !rst && rnd_valid && (|req_valid);
    assign rnd_ready = issue;

    mskg16_sched_rr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req      (req_valid),
        .ptr      (ptr),
        .en       (issue),
        .grant    (req_ready),
        .grant_id (grant_id),
        .ptr_nxt  (ptr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_nxt;
    end

    assign sel_a = req_a[int'(grant_id)*W +: W];
    assign sel_b = req_b[int'(grant_id)*W +: W];

`ifdef MSKG16_SCHED_ZEROIZE_EN
    assign g_inb     = issue ? sel_b : '0;
    assign g_rnd_ref = issue ? rnd[NR-1:0] : '0;
`else
    logic [W-1:0]  b_hold;
    logic [NR-1:0] r_hold;

    always_ff @(posedge clk) begin
        if (issue) begin
            b_hold <= sel_b;
            r_hold <= rnd[NR-1:0];
        end
    end

    assign g_inb     = issue ? sel_b : b_hold;
    assign g_rnd_ref = issue ? rnd[NR-1:0] : r_hold;
`endif

    // a and DOM bits trail b by 1+REF_LAT to meet the gadget's skew.
    logic [W-1:0]  a_dly [DL];
    logic [NM-1:0] m_dly [DL];

    always_ff @(posedge clk) begin
        if (issue) begin
            a_dly[0] <= sel_a;
            m_dly[0] <= rnd[RND_W-1:NR];
        end
`ifdef MSKG16_SCHED_ZEROIZE_EN
        else begin
            a_dly[0] <= '0;
            m_dly[0] <= '0;
        end
`endif
        for (int k = 1; k < DL; k++) begin
            a_dly[k] <= a_dly[k-1];
            m_dly[k] <= m_dly[k-1];
        end
    end

    assign g_ina     = a_dly[DL-1];
    assign g_rnd_mul = m_dly[DL-1];

    tag_t tags [PL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PL; k++) tags[k] <= '0;
        end else begin
            tags[0] <= '{valid: issue, id: MAX_IDW'(grant_id)};
            for (int k = 1; k < PL; k++) tags[k] <= tags[k-1];
        end
    end

    logic tag_unused;
    assign tag_unused = ^tags[PL-1].id;

    assign resp_valid = tags[PL-1].valid;
    assign resp_id    = tags[PL-1].id[IDW-1:0];

    always_comb begin
        busy = issue;
        for (int k = 0; k < PL; k++) busy = busy | tags[k].valid;
    end

    MSKg16mul_hpc1 #(
        .D         (D),
        .REF_LAT   (REF_LAT),
        .REF_N_RND (REF_N_RND),
        .DOM_RND   (DOM_RND)
    ) u_mul (
        .clk     (clk),
        .ina     (g_ina),
        .inb     (g_inb),
        .rnd_ref (g_rnd_ref),
        .rnd_mul (g_rnd_mul),
        .out     (resp_out)
    );

endmodule

// File: tb/tb_mskg16mul_sched.sv
// Scoreboard bench: two schedulers (REF_LAT 0 and 1) share one stimulus stream.
module tb_mskg16mul_sched;

    localparam int D     = 2;
    localparam int NREQ  = 4;
    localparam int W     = 4 * D;
    localparam int RND_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rnd_valid;
    logic [RND_W-1:0]  rnd;

    logic [NREQ-1:0] rdy0, rdy1;
    logic            rr0, rr1, rv0, rv1, busy0, busy1;
    logic [1:0]      rid0, rid1;
    logic [W-1:0]    ro0, ro1;

    always #5 clk = ~clk;

    mskg16mul_sched #(.D(D), .NREQ(NREQ), .REF_LAT(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_a(req_a), .req_b(req_b), .rnd_valid(rnd_valid),
        .rnd_ready(rr0), .rnd(rnd), .resp_valid(rv0), .resp_id(rid0),
        .resp_out(ro0), .busy(busy0)
    );

    mskg16mul_sched #(.D(D), .NREQ(NREQ), .REF_LAT(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_a(req_a), .req_b(req_b), .rnd_valid(rnd_valid),
        .rnd_ready(rr1), .rnd(rnd), .resp_valid(rv1), .resp_id(rid1),
        .resp_out(ro1), .busy(busy1)
    );

    typedef struct {
        int         id;
        logic [3:0] p;
        int         t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    // Fixed operands per requester, products hand-reduced mod x^4+x+1.
    logic [3:0] op_a [NREQ] = '{4'h3, 4'h2, 4'h7, 4'hF};
    logic [3:0] op_b [NREQ] = '{4'h5, 4'h8, 4'h6, 4'hF};
    logic [3:0] op_p [NREQ] = '{4'hF, 4'h3, 4'h1, 4'hA};

    logic [W-1:0] last_a, last_b;
    logic [3:0]   last_r;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] share(input logic [3:0] v);
        logic [W-1:0] x;
        logic         acc, r;
        x = '0;
        for (int k = 0; k < 4; k++) begin
            acc = 1'b0;
            for (int s = 0; s < D - 1; s++) begin
                r = 1'($urandom);
                x[k*D+s] = r;
                acc = acc ^ r;
            end
            x[k*D+D-1] = v[k] ^ acc;
        end
        return x;
    endfunction

    function automatic logic [3:0] unmask(input logic [W-1:0] x);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            for (int s = 0; s < D; s++)
                v[k] = v[k] ^ x[k*D+s];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic pop_chk(input int u, input logic [1:0] id,
                           input logic [W-1:0] o);
        exp_t e;
        int   lat;
        lat = (u == 0) ? 2 : 3;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_resp u%0d: got id %0d want none",
                     u, id);
        end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("resp_id_u%0d", u), 32'(id), 32'(e.id));
            chk($sformatf("product_u%0d", u), 32'(unmask(o)), 32'(e.p));
            chk($sformatf("latency_u%0d", u), 32'(cyc - e.t), 32'(lat));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rv0) pop_chk(0, rid0, ro0);
            if (rv1) pop_chk(1, rid1, ro1);
        end
    end

    task automatic step(input logic [NREQ-1:0] v, input logic rv,
                        input int g);
        logic [NREQ-1:0] eg;
        exp_t            e;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = share(op_a[i]);
            req_b[i*W +: W] = share(op_b[i]);
        end
        req_valid = v;
        rnd_valid = rv;
        rnd       = RND_W'($urandom);
        #1;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready_u0", 32'(rdy0), 32'(eg));
        chk("req_ready_u1", 32'(rdy1), 32'(eg));
        chk("rnd_ready", 32'(rr0), 32'(g >= 0));
        if (g >= 0) begin
            e.id = g;
            e.p  = op_p[g];
            e.t  = cyc;
            q0.push_back(e);
            q1.push_back(e);
            last_a = req_a[g*W +: W];
            last_b = req_b[g*W +: W];
            last_r = rnd[3:0];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b1, -1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rnd_valid = 1'b0;
        rnd       = '0;
        req_a     = '0;
        req_b     = '0;
        last_a    = '0;
        last_b    = '0;
        last_r    = '0;
        #1;
        chk("rst_resp_valid", 32'(rv0 | rv1), 0);
        chk("rst_busy", 32'(busy0 | busy1), 0);
        chk("rst_resp_id", 32'(rid0), 0);
        chk("rst_ptr", 32'(u0.ptr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single op, then watch bubble behaviour on the gadget inputs.
        step(4'b0001, 1'b1, 0);
        step('0, 1'b1, -1);
`ifdef MSKG16_SCHED_ZEROIZE_EN
        chk("bubble_inb", 32'(u0.g_inb), 0);
        chk("bubble_rnd_ref", 32'(u0.g_rnd_ref), 0);
`else
        chk("bubble_inb", 32'(u0.g_inb), 32'(last_b));
        chk("bubble_rnd_ref", 32'(u0.g_rnd_ref), 32'(last_r));
`endif
        chk("ina_t1_u0", 32'(u0.g_ina), 32'(last_a));
        step('0, 1'b1, -1);
        chk("ina_t2_u1", 32'(u1.g_ina), 32'(last_a));
`ifdef MSKG16_SCHED_ZEROIZE_EN
        chk("bubble_ina", 32'(u0.g_ina), 0);
`else
        chk("bubble_ina", 32'(u0.g_ina), 32'(last_a));
`endif
        idle(3);

        // All valid: pointer sits at 1 after the first grant.
        step(4'b1111, 1'b1, 1);
        step(4'b1111, 1'b1, 2);
        step(4'b1111, 1'b1, 3);
        step(4'b1111, 1'b1, 0);
        step(4'b1111, 1'b1, 1);
        step(4'b1111, 1'b1, 2);
        step(4'b1111, 1'b1, 3);
        step(4'b1111, 1'b1, 0);
        idle(4);

        // PRNG starvation stalls the grant.
        step(4'b0010, 1'b0, -1);
        step(4'b0010, 1'b0, -1);
        step(4'b0010, 1'b0, -1);
        chk("stall_busy", 32'(busy0), 0);
        step(4'b0010, 1'b1, 1);
        idle(4);

        // Pointer at 2 skips idle 2,3 and wraps to 0.
        step(4'b0001, 1'b1, 0);
        step(4'b1000, 1'b1, 3);
        step(4'b0100, 1'b1, 2);
        step(4'b0100, 1'b1, 2);
        step(4'b0100, 1'b1, 2);
        idle(4);

        // Reset with ops in flight drops them all.
        step(4'b1111, 1'b1, 3);
        step(4'b1111, 1'b1, 0);
        @(negedge clk);
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(rv0 | rv1), 0);
        chk("midrst_busy", 32'(busy0 | busy1), 0);
        chk("midrst_ptr_u0", 32'(u0.ptr), 0);
        chk("midrst_ptr_u1", 32'(u1.ptr), 0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(6);
        step(4'b1111, 1'b1, 0);
        idle(1);

        begin
            int n;
            n = 0;
            while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            n_vec++;
            if (q0.size() != 0 || q1.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d/%0d pending want 0/0",
                         q0.size(), q1.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
